// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, conditional jump, call/return through a
// small return-address stack, stall, and halt/resume with a sticky fault state.
module pc_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         jmp_en,
  input  logic [2:0]                   jmp_cond,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt,
  input  logic                         resume,
  input  logic [PC_W-1:0]              target,
  input  logic [3:0]                   flags,
  output logic [PC_W-1:0]              pc,
  output logic                         halted,
  output logic                         fault,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = AW + 1;

  typedef enum logic [1:0] {StRun, StHalted, StFault} state_e;

  state_e          state;
  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [PC_W-1:0] pc_inc;
  logic [AW-1:0]   push_idx;
  logic [AW-1:0]   top_idx;
  logic            full;
  logic            empty;
  logic            take;

  assign pc_inc   = pc + PC_W'(1);
  assign push_idx = depth[AW-1:0];
  assign top_idx  = push_idx - AW'(1);
  assign full     = (depth == DW'(STACK_DEPTH));
  assign empty    = (depth == '0);

  assign halted = (state == StHalted);
  assign fault  = (state == StFault);

  // flags: [3]=Z, [2]=N, [1]=C, [0]=V
  always_comb begin
    take = 1'b0;
    case (jmp_cond)
      3'b000:  take = 1'b1;
      3'b001:  take = flags[3];
      3'b010:  take = !flags[3];
      3'b011:  take = !flags[3] && !flags[2];
      3'b100:  take = !flags[2];
      3'b101:  take = flags[2];
      3'b110:  take = flags[2] || flags[3];
      3'b111:  take = flags[1];
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StRun;
      pc        <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!stall) begin
      case (state)
        StRun: begin
          if (halt) begin
            state <= StHalted;
          end else if (ret) begin
            if (empty) begin
              underflow <= 1'b1;
              state     <= StFault;
            end else begin
              pc    <= stack[top_idx];
              depth <= depth - DW'(1);
            end
          end else if (call) begin
            if (full) begin
              overflow <= 1'b1;
              state    <= StFault;
            end else begin
              stack[push_idx] <= pc_inc;
              pc              <= target;
              depth           <= depth + DW'(1);
            end
          end else if (jmp_en && take) begin
            pc <= target;
          end else begin
            pc <= pc_inc;
          end
        end
        StHalted: begin
          // Continue with the instruction after the one that halted.
          if (resume) begin
            state <= StRun;
            pc    <= pc_inc;
          end
        end
        StFault: begin
        end
        default: state <= StFault;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, increment wrap, jumps, call/ret,
// stack limits, halt/resume, stall and request priority.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, jmp_en, call, ret, halt, resume;
  logic [2:0] jmp_cond;
  logic [7:0] target;
  logic [3:0] flags;
  logic [7:0] pc;
  logic       halted, fault, overflow, underflow;
  logic [2:0] depth;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .jmp_en   (jmp_en),
    .jmp_cond (jmp_cond),
    .call     (call),
    .ret      (ret),
    .halt     (halt),
    .resume   (resume),
    .target   (target),
    .flags    (flags),
    .pc       (pc),
    .halted   (halted),
    .fault    (fault),
    .overflow (overflow),
    .underflow(underflow),
    .depth    (depth)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; jmp_en = 0; jmp_cond = 3'b000; call = 0; ret = 0;
    halt = 0; resume = 0; target = 8'h00; flags = 4'b0000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'h0);
    chk({tag, ".depth"}, 32'(depth), 32'h0);
    chk({tag, ".halted"}, 32'(halted), 32'h0);
    chk({tag, ".fault"}, 32'(fault), 32'h0);
    chk({tag, ".overflow"}, 32'(overflow), 32'h0);
    chk({tag, ".underflow"}, 32'(underflow), 32'h0);
  endtask

  // Reset, then an always-taken jump to place the PC at a chosen address.
  task automatic go_to(input logic [7:0] addr);
    idle(); rst = 1; step();
    idle(); jmp_en = 1; target = addr; step();
    idle();
  endtask

  function automatic logic ref_take(input logic [2:0] c, input logic [3:0] f);
    logic z, n, cy;
    z = f[3]; n = f[2]; cy = f[1];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !z && !n;
      3'd4: return !n;
      3'd5: return n;
      3'd6: return n || z;
      default: return cy;
    endcase
  endfunction

  initial begin
    logic [7:0] exp_pc;
    logic [3:0] fpat [4];
    fpat[0] = 4'b0000; fpat[1] = 4'b1000; fpat[2] = 4'b0100; fpat[3] = 4'b0010;

    // Reset and free-running increment with wrap
    idle(); rst = 1; step();
    chk_reset("reset");
    idle();
    exp_pc = 8'h00;
    for (int i = 1; i < 300; i++) begin
      step();
      exp_pc = exp_pc + 8'h01;
      chk("incr.pc", 32'(pc), 32'(exp_pc));
    end
    chk("incr.pc_final", 32'(pc), 32'h2B);
    chk("incr.fault", 32'(fault), 32'h0);
    chk("incr.depth", 32'(depth), 32'h0);

    // Spec examples for conditional jump
    go_to(8'h05);
    jmp_en = 1; jmp_cond = 3'b001; target = 8'h40; flags = 4'b1000; step(); idle();
    chk("jz_taken.pc", 32'(pc), 32'h40);
    go_to(8'h05);
    jmp_en = 1; jmp_cond = 3'b001; target = 8'h40; flags = 4'b0000; step(); idle();
    chk("jz_not.pc", 32'(pc), 32'h06);
    go_to(8'h05);
    jmp_en = 1; jmp_cond = 3'b110; target = 8'h40; flags = 4'b0100; step(); idle();
    chk("jle_taken.pc", 32'(pc), 32'h40);

    // Every condition code against a few flag patterns
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 4; f++) begin
        go_to(8'h05);
        jmp_en = 1; jmp_cond = 3'(c); target = 8'hA0; flags = fpat[f]; step(); idle();
        chk($sformatf("cond%0d_f%0h.pc", c, fpat[f]), 32'(pc),
            ref_take(3'(c), fpat[f]) ? 32'hA0 : 32'h06);
      end
    end

    // Nested call/ret
    go_to(8'h10);
    call = 1; target = 8'h80; step(); idle();
    chk("call1.pc", 32'(pc), 32'h80);
    chk("call1.depth", 32'(depth), 32'h1);
    step();
    chk("call1.inc", 32'(pc), 32'h81);
    call = 1; target = 8'hC0; step(); idle();
    chk("call2.pc", 32'(pc), 32'hC0);
    chk("call2.depth", 32'(depth), 32'h2);
    ret = 1; step(); idle();
    chk("ret1.pc", 32'(pc), 32'h82);
    chk("ret1.depth", 32'(depth), 32'h1);
    ret = 1; step(); idle();
    chk("ret2.pc", 32'(pc), 32'h11);
    chk("ret2.depth", 32'(depth), 32'h0);

    // Return address wraps from 0xFF
    go_to(8'hFF);
    call = 1; target = 8'h33; step(); idle();
    ret = 1; step(); idle();
    chk("wrap_ret.pc", 32'(pc), 32'h00);

    // Overflow on the fifth nested call
    idle(); rst = 1; step(); idle();
    for (int i = 1; i <= 4; i++) begin
      call = 1; target = 8'h50; step(); idle();
      chk("fill.depth", 32'(depth), 32'(i));
      chk("fill.pc", 32'(pc), 32'h50);
    end
    call = 1; target = 8'h90; step(); idle();
    chk("ovf.pc", 32'(pc), 32'h50);
    chk("ovf.overflow", 32'(overflow), 32'h1);
    chk("ovf.fault", 32'(fault), 32'h1);
    chk("ovf.depth", 32'(depth), 32'h4);
    chk("ovf.underflow", 32'(underflow), 32'h0);
    jmp_en = 1; target = 8'h12; step(); step(); idle(); ret = 1; step(); idle();
    chk("fault_frozen.pc", 32'(pc), 32'h50);
    chk("fault_frozen.depth", 32'(depth), 32'h4);
    chk("fault_frozen.fault", 32'(fault), 32'h1);
    rst = 1; step(); idle();
    chk_reset("rst_fault");

    // Underflow on ret at depth 0
    ret = 1; step(); idle();
    chk("udf.underflow", 32'(underflow), 32'h1);
    chk("udf.fault", 32'(fault), 32'h1);
    chk("udf.pc", 32'(pc), 32'h0);
    chk("udf.overflow", 32'(overflow), 32'h0);

    // Halt ignores other requests, resume continues at pc+1
    go_to(8'h20);
    halt = 1; step(); idle();
    chk("halt.halted", 32'(halted), 32'h1);
    chk("halt.pc", 32'(pc), 32'h20);
    for (int i = 0; i < 5; i++) begin
      jmp_en = 1; target = 8'h77; call = (i == 2); step(); idle();
      chk("halted_hold.pc", 32'(pc), 32'h20);
    end
    chk("halted_hold.depth", 32'(depth), 32'h0);
    resume = 1; step(); idle();
    chk("resume.pc", 32'(pc), 32'h21);
    chk("resume.halted", 32'(halted), 32'h0);
    step();
    chk("resume.inc", 32'(pc), 32'h22);

    // Stalled resume does nothing
    halt = 1; step(); idle();
    resume = 1; stall = 1; step(); idle();
    chk("stall_resume.halted", 32'(halted), 32'h1);
    chk("stall_resume.pc", 32'(pc), 32'h22);

    // halt + resume in RUN: halt wins; then reset out of HALTED
    go_to(8'h30);
    halt = 1; resume = 1; step(); idle();
    chk("halt_resume.halted", 32'(halted), 32'h1);
    chk("halt_resume.pc", 32'(pc), 32'h30);
    rst = 1; step(); idle();
    chk_reset("rst_halted");

    // Call held across a 3-cycle stall executes once, 3 cycles late
    go_to(8'h60);
    call = 1; target = 8'h90; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.pc", 32'(pc), 32'h60);
      chk("stall.depth", 32'(depth), 32'h0);
    end
    stall = 0; step(); idle();
    chk("stall_call.pc", 32'(pc), 32'h90);
    chk("stall_call.depth", 32'(depth), 32'h1);
    step();
    chk("stall_call.inc", 32'(pc), 32'h91);

    // Reset wins over stall
    rst = 1; stall = 1; step(); idle();
    chk_reset("rst_stall");

    // ret beats call and jmp_en at depth 1
    go_to(8'h10);
    call = 1; target = 8'h80; step(); idle();
    ret = 1; call = 1; jmp_en = 1; target = 8'h99; step(); idle();
    chk("prio.pc", 32'(pc), 32'h11);
    chk("prio.depth", 32'(depth), 32'h0);
    chk("prio.fault", 32'(fault), 32'h0);

    // call beats jmp_en
    call = 1; jmp_en = 1; target = 8'h44; step(); idle();
    chk("prio_call.pc", 32'(pc), 32'h44);
    chk("prio_call.depth", 32'(depth), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
